// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI-Lite response codes, manager state encoding and default prot.
package axi_lite_pkg;
   typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} axi_resp_e;
   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} mgr_state_e;
   localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/axi_lite_manager.sv
// axi_lite_manager: single-outstanding AXI4-Lite manager behind a local valid/ready command/response port.
// Define AXIL_MGR_TIMEOUT_EN to add the per-state watchdog and the sticky timeout_o output.
module axi_lite_manager
   import axi_lite_pkg::*;
#(
   parameter int         AXIL_ADDR_WIDTH = 32,
   parameter int         AXIL_DATA_WIDTH = 32,
   parameter logic [2:0] AXIL_PROT       = AXIL_PROT_DEFAULT,
   parameter int         TIMEOUT_CYCLES  = 1024,
   localparam int        AXILSizeBytes   = AXIL_DATA_WIDTH / 8
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
`ifdef AXIL_MGR_TIMEOUT_EN
   output logic                       timeout_o,
`endif
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic                       req_we_i,
   input  logic [AXIL_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [AXIL_DATA_WIDTH-1:0] req_wdata_i,
   input  logic [AXILSizeBytes-1:0]   req_wstrb_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic                       rsp_we_o,
   output logic [AXIL_DATA_WIDTH-1:0] rsp_rdata_o,
   output logic [1:0]                 rsp_resp_o,
   output logic [AXIL_ADDR_WIDTH-1:0] aw_addr_o,
   output logic [2:0]                 aw_prot_o,
   output logic                       aw_valid_o,
   input  logic                       aw_ready_i,
   output logic [AXIL_DATA_WIDTH-1:0] w_data_o,
   output logic [AXILSizeBytes-1:0]   w_strb_o,
   output logic                       w_valid_o,
   input  logic                       w_ready_i,
   input  logic [1:0]                 b_resp_i,
   input  logic                       b_valid_i,
   output logic                       b_ready_o,
   output logic [AXIL_ADDR_WIDTH-1:0] ar_addr_o,
   output logic [2:0]                 ar_prot_o,
   output logic                       ar_valid_o,
   input  logic                       ar_ready_i,
   input  logic [AXIL_DATA_WIDTH-1:0] r_data_i,
   input  logic [1:0]                 r_resp_i,
   input  logic                       r_valid_i,
   output logic                       r_ready_o
);
   mgr_state_e                 state_q, state_d;
   logic                       req_ready_q, req_ready_d;
   logic [AXIL_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AXIL_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [AXILSizeBytes-1:0]   wstrb_q, wstrb_d;
   logic                       aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d;
   logic                       ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
   logic                       rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d;
   logic [AXIL_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]                 rsp_resp_q, rsp_resp_d;
`ifdef AXIL_MGR_TIMEOUT_EN
   localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_q, timeout_d;
   assign timeout_o = timeout_q;
`endif

   // One address register serves both channels; only one of them is ever valid.
   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_we_o    = rsp_we_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_resp_o  = rsp_resp_q;
   assign aw_addr_o   = addr_q;
   assign ar_addr_o   = addr_q;
   assign aw_prot_o   = AXIL_PROT;
   assign ar_prot_o   = AXIL_PROT;
   assign aw_valid_o  = aw_valid_q;
   assign w_data_o    = wdata_q;
   assign w_strb_o    = wstrb_q;
   assign w_valid_o   = w_valid_q;
   assign b_ready_o   = b_ready_q;
   assign ar_valid_o  = ar_valid_q;
   assign r_ready_o   = r_ready_q;

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      aw_valid_d  = aw_valid_q;
      w_valid_d   = w_valid_q;
      b_ready_d   = b_ready_q;
      ar_valid_d  = ar_valid_q;
      r_ready_d   = r_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_we_d    = rsp_we_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid_i && req_ready_q) begin
               req_ready_d = 1'b0;
               addr_d      = req_addr_i;
               wdata_d     = req_wdata_i;
               wstrb_d     = req_wstrb_i;
               rsp_we_d    = req_we_i;
               rsp_rdata_d = '0;
               aw_valid_d  = req_we_i;
               w_valid_d   = req_we_i;
               ar_valid_d  = !req_we_i;
               state_d     = req_we_i ? WR_AW_W : RD_AR;
            end
         end
         WR_AW_W: begin
            // A deasserted valid doubles as that channel's done flag.
            aw_valid_d = aw_valid_q && !aw_ready_i;
            w_valid_d  = w_valid_q && !w_ready_i;
            if (!aw_valid_d && !w_valid_d) begin
               b_ready_d = 1'b1;
               state_d   = WR_B;
            end
         end
         WR_B: begin
            if (b_valid_i) begin
               rsp_resp_d  = b_resp_i;
               b_ready_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         RD_AR: begin
            if (ar_ready_i) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               state_d    = RD_R;
            end
         end
         RD_R: begin
            if (r_valid_i) begin
               rsp_rdata_d = r_data_i;
               rsp_resp_d  = r_resp_i;
               r_ready_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef AXIL_MGR_TIMEOUT_EN
      timeout_d = timeout_q;
      cnt_d     = (state_d != state_q) ? '0 : cnt_q + 1'b1;
      if (state_q inside {WR_AW_W, WR_B, RD_AR, RD_R} && state_d == state_q &&
          cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
         aw_valid_d  = 1'b0;
         w_valid_d   = 1'b0;
         b_ready_d   = 1'b0;
         ar_valid_d  = 1'b0;
         r_ready_d   = 1'b0;
         rsp_resp_d  = DECERR;
         rsp_rdata_d = '0;
         rsp_valid_d = 1'b1;
         timeout_d   = 1'b1;
         cnt_d       = '0;
         state_d     = RSP;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         b_ready_q   <= 1'b0;
         ar_valid_q  <= 1'b0;
         r_ready_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         aw_valid_q  <= aw_valid_d;
         w_valid_q   <= w_valid_d;
         b_ready_q   <= b_ready_d;
         ar_valid_q  <= ar_valid_d;
         r_ready_q   <= r_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

`ifdef AXIL_MGR_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
`endif
endmodule

// File: tb/tb_axi_lite_manager.sv
// tb_axi_lite_manager: randomized scoreboard bench with an AXI-Lite register-bank subordinate model.
module tb_axi_lite_manager;
   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b1;
   logic        req_valid_i = 1'b0, req_we_i = 1'b0, rsp_ready_i = 1'b0;
   logic [31:0] req_addr_i = '0, req_wdata_i = '0, r_data_i = '0;
   logic [3:0]  req_wstrb_i = '0;
   logic        aw_ready_i = 1'b0, w_ready_i = 1'b0, b_valid_i = 1'b0, ar_ready_i = 1'b0, r_valid_i = 1'b0;
   logic [1:0]  b_resp_i = '0, r_resp_i = '0;
   logic        req_ready_o, rsp_valid_o, rsp_we_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o;
   logic [31:0] rsp_rdata_o, aw_addr_o, w_data_o, ar_addr_o;
   logic [1:0]  rsp_resp_o;
   logic [2:0]  aw_prot_o, ar_prot_o;
   logic [3:0]  w_strb_o;
`ifdef AXIL_MGR_TIMEOUT_EN
   logic        timeout_o;
`endif

   always #5 clk_i = ~clk_i;

   axi_lite_manager dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
`ifdef AXIL_MGR_TIMEOUT_EN
      .timeout_o(timeout_o),
`endif
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_we_o(rsp_we_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
      .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
      .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
      .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
      .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
      .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
   );

   int checks = 0, failures = 0;
   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
      return old;
   endfunction

   typedef struct {logic we; logic [31:0] rdata; logic [1:0] resp;} rsp_t;
   typedef struct {logic [31:0] d; logic [3:0] s;} wbeat_t;
   rsp_t        exp_q[$];
   logic [31:0] aw_exp_q[$], ar_exp_q[$];
   wbeat_t      w_exp_q[$];
   logic [1:0]  bresp_q[$], rresp_q[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] sub_mem[logic [31:0]];

   bit zero_wait = 1'b0;
   int force_b_delay = -1, force_r_delay = -1, hold_rsp = 0;

   // Subordinate: random ready/valid timing, register bank, channel protocol checks.
   bit          aw_got, w_got, b_pend, r_pend, b_hs, r_hs, aw_stall, w_stall, ar_stall;
   int          b_cnt, r_cnt;
   logic [31:0] aw_a, ar_a, w_d, aw_prev, ar_prev, wd_prev;
   logic [3:0]  w_s, ws_prev;
   always @(negedge clk_i) begin
      if (!rstn_i) begin
         aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
         b_resp_i = 0; r_resp_i = 0; r_data_i = 0;
         aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_hs = 0; r_hs = 0;
         aw_stall = 0; w_stall = 0; ar_stall = 0;
      end else begin
         if (b_hs) b_valid_i = 0;
         if (r_hs) r_valid_i = 0;
         if (aw_stall) chk("aw_hold", {aw_valid_o, aw_addr_o}, {1'b1, aw_prev});
         if (w_stall) chk("w_hold", {w_valid_o, w_data_o, w_strb_o}, {1'b1, wd_prev, ws_prev});
         if (ar_stall) chk("ar_hold", {ar_valid_o, ar_addr_o}, {1'b1, ar_prev});
         if (b_ready_o) chk("b_ready_early", {aw_valid_o, w_valid_o}, 2'b00);
         aw_ready_i = zero_wait || $urandom_range(0, 2) == 0;
         w_ready_i  = zero_wait || $urandom_range(0, 2) == 0;
         ar_ready_i = zero_wait || $urandom_range(0, 2) == 0;
         if (aw_got && w_got) begin
            sub_mem[aw_a] = merge(sub_mem.exists(aw_a) ? sub_mem[aw_a] : 32'h0, w_d, w_s);
            aw_got = 0; w_got = 0; b_pend = 1;
            b_cnt = force_b_delay >= 0 ? force_b_delay : zero_wait ? 0 : int'($urandom_range(0, 3));
         end
         if (b_pend && !b_valid_i) begin
            if (b_cnt == 0) begin
               b_valid_i = 1; b_pend = 0;
               b_resp_i = bresp_q.size() ? bresp_q.pop_front() : 2'b00;
            end else b_cnt--;
         end
         if (r_pend && !r_valid_i) begin
            if (r_cnt == 0) begin
               r_valid_i = 1; r_pend = 0;
               r_data_i = sub_mem.exists(ar_a) ? sub_mem[ar_a] : 32'h0;
               r_resp_i = rresp_q.size() ? rresp_q.pop_front() : 2'b00;
            end else r_cnt--;
         end
         if (aw_valid_o && aw_ready_i) begin
            aw_got = 1; aw_a = aw_addr_o;
            chk("aw_addr", aw_addr_o, aw_exp_q.size() ? aw_exp_q.pop_front() : 'x);
         end
         if (w_valid_o && w_ready_i) begin
            wbeat_t e;
            w_got = 1; w_d = w_data_o; w_s = w_strb_o;
            e = w_exp_q.size() ? w_exp_q.pop_front() : '{d: 'x, s: 'x};
            chk("w_beat", {w_data_o, w_strb_o}, {e.d, e.s});
         end
         if (ar_valid_o && ar_ready_i) begin
            ar_a = ar_addr_o; r_pend = 1;
            r_cnt = force_r_delay >= 0 ? force_r_delay : zero_wait ? 0 : int'($urandom_range(0, 3));
            chk("ar_addr", ar_addr_o, ar_exp_q.size() ? ar_exp_q.pop_front() : 'x);
         end
         b_hs = b_valid_i && b_ready_o;
         r_hs = r_valid_i && r_ready_o;
         aw_stall = aw_valid_o && !aw_ready_i; aw_prev = aw_addr_o;
         w_stall = w_valid_o && !w_ready_i; wd_prev = w_data_o; ws_prev = w_strb_o;
         ar_stall = ar_valid_o && !ar_ready_i; ar_prev = ar_addr_o;
      end
   end

   // Response monitor / scoreboard.
   bit          rsp_stall;
   logic [34:0] rsp_prev;
   always @(negedge clk_i) begin
      if (!rstn_i) begin
         rsp_ready_i = 0; rsp_stall = 0;
      end else begin
         if (rsp_valid_o && hold_rsp > 0) begin
            rsp_ready_i = 0; hold_rsp--;
         end else rsp_ready_i = zero_wait || $urandom_range(0, 2) != 0;
         if (rsp_stall) chk("rsp_hold", {rsp_valid_o, rsp_we_o, rsp_rdata_o, rsp_resp_o}, {1'b1, rsp_prev});
         if (rsp_valid_o) chk("req_ready_in_rsp", req_ready_o, 1'b0);
         if (rsp_valid_o && rsp_ready_i) begin
            rsp_t e;
            e = exp_q.size() ? exp_q.pop_front() : '{we: 'x, rdata: 'x, resp: 'x};
            chk("rsp_we", rsp_we_o, e.we);
            chk("rsp_rdata", rsp_rdata_o, e.rdata);
            chk("rsp_resp", rsp_resp_o, e.resp);
         end
         rsp_stall = rsp_valid_o && !rsp_ready_i;
         rsp_prev = {rsp_we_o, rsp_rdata_o, rsp_resp_o};
      end
   end

   // Present a command and return at the first falling edge after it was accepted.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] resp);
      int n = 0;
      req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_wdata_i = data; req_wstrb_i = strb;
      while (!req_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (!req_ready_o) begin
         chk("req_ready_wait", req_ready_o, 1'b1);
         req_valid_i = 0;
         return;
      end
      if (we) begin
         ref_mem[addr] = merge(ref_mem.exists(addr) ? ref_mem[addr] : 32'h0, data, strb);
         aw_exp_q.push_back(addr);
         w_exp_q.push_back('{d: data, s: strb});
         bresp_q.push_back(resp);
         exp_q.push_back('{we: 1'b1, rdata: 32'h0, resp: resp});
      end else begin
         ar_exp_q.push_back(addr);
         rresp_q.push_back(resp);
         exp_q.push_back('{we: 1'b0, rdata: ref_mem.exists(addr) ? ref_mem[addr] : 32'h0, resp: resp});
      end
      @(negedge clk_i);
      req_valid_i = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !req_ready_o) && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      ref_mem[32'h2C] = 32'h7;
      sub_mem[32'h2C] = 32'h7;
      #1 rstn_i = 0;
      #1 chk("reset_outputs", {req_ready_o, rsp_valid_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o},
                              7'b0);
      chk("reset_data", {aw_addr_o, w_data_o, rsp_rdata_o, rsp_resp_o, rsp_we_o}, 99'b0);
      repeat (2) @(negedge clk_i);
      rstn_i = 1;
      #1 chk("req_ready_at_release", req_ready_o, 1'b0);
      @(negedge clk_i);
      chk("req_ready_after_release", req_ready_o, 1'b1);

      // Zero-wait write: AW/W valid one cycle after accept, response two cycles later.
      zero_wait = 1;
      issue(1'b1, 32'h0C, 32'hDEAD_BEEF, 4'hF, 2'b00);
      chk("wr_aw_w_valid", {aw_valid_o, w_valid_o, aw_prot_o}, 5'b11000);
      @(negedge clk_i);
      chk("wr_b_phase", {rsp_valid_o, b_ready_o, aw_valid_o, w_valid_o}, 4'b0100);
      @(negedge clk_i);
      chk("wr_rsp_latency", rsp_valid_o, 1'b1);
      drain();

      // Read with a 3-cycle R delay; AR drops right after its handshake.
      force_r_delay = 3;
      issue(1'b0, 32'h2C, 32'h0, 4'h0, 2'b00);
      chk("rd_ar_valid", {ar_valid_o, ar_addr_o}, {1'b1, 32'h2C});
      @(negedge clk_i);
      chk("rd_ar_dropped", {ar_valid_o, r_ready_o}, 2'b01);
      drain();
      force_r_delay = -1;

      // SLVERR read with the response held off for five cycles.
      zero_wait = 0;
      hold_rsp = 5;
      issue(1'b0, 32'h0C, 32'h0, 4'h0, 2'b10);
      drain();

      // Reset while waiting for B: everything drops at once, no response afterwards.
      zero_wait = 1;
      force_b_delay = 10;
      issue(1'b1, 32'h80, 32'h1234_5678, 4'hF, 2'b00);
      repeat (2) @(negedge clk_i);
      chk("in_wr_b", {b_ready_o, rsp_valid_o}, 2'b10);
      rstn_i = 0;
      #1 chk("midreset_outputs", {req_ready_o, rsp_valid_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o},
                                 7'b0);
      exp_q.delete(); aw_exp_q.delete(); ar_exp_q.delete(); w_exp_q.delete(); bresp_q.delete(); rresp_q.delete();
      force_b_delay = -1;
      repeat (2) @(negedge clk_i);
      rstn_i = 1;
      #1 chk("req_ready_at_rerelease", req_ready_o, 1'b0);
      @(negedge clk_i);
      chk("req_ready_after_rerelease", {req_ready_o, rsp_valid_o}, 2'b10);
      repeat (3) begin
         @(negedge clk_i);
         chk("no_rsp_after_reset", rsp_valid_o, 1'b0);
      end

      // Randomized traffic over a small register window.
      zero_wait = 0;
      for (int t = 0; t < 60; t++) begin
         logic [1:0] rsp;
         rsp = $urandom_range(0, 3) != 0 ? 2'b00 : 2'($urandom_range(1, 3));
         issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom, 4'($urandom_range(0, 15)), rsp);
         repeat ($urandom_range(0, 3)) @(negedge clk_i);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end
endmodule
